booth_mul_seq: RTL



---
 rtl/booth_mul_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Operand/result sequencer wrapped around an external combinational Booth multiplier.
// Optional accumulate mode is enabled by defining BOOTH_MUL_ACC_EN.
module booth_mul_seq #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
`ifdef BOOTH_MUL_ACC_EN
    input  logic               acc_clr,
`endif
    output logic               busy
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("booth_mul_seq: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] result;
    logic               accept;

`ifdef BOOTH_MUL_ACC_EN
    logic acc_clr_q, acc_clr_d;

    // p_q doubles as the running accumulator: it only changes at CALC completion.
    assign result = (acc_clr_q ? '0 : p_q) + mul_p;
`else
    assign result = mul_p;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
`ifdef BOOTH_MUL_ACC_EN
            acc_clr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
`ifdef BOOTH_MUL_ACC_EN
            acc_clr_q <= acc_clr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        p_d      = p_q;
        in_ready = 1'b0;
`ifdef BOOTH_MUL_ACC_EN
        acc_clr_d = acc_clr_q;
`endif
        case (state_q)
            IDLE: in_ready = 1'b1;
            CALC: begin
                if (cnt_q == 4'd0) begin
                    p_d     = result;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new pair is taken from IDLE, or from DONE on the same edge the result retires.
        accept = in_valid && in_ready;
        if (accept) begin
            x_d     = in_x;
            y_d     = in_y;
            cnt_d   = CNT_INIT;
            state_d = CALC;
`ifdef BOOTH_MUL_ACC_EN
            acc_clr_d = acc_clr;
`endif
        end
    end

    assign mul_x     = x_q;
    assign mul_y     = y_q;
    assign out_p     = p_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
